// File: rtl/dm_port_arbiter_if.sv
// Bus bundle for dm_port_arbiter: CPU port, DMA/loader port and the
// registered data-memory port. The arbiter connects through the slave
// modport; whatever drives the requests and models the memory uses master.
interface dm_port_arbiter_if;
  // CPU (EX-stage) port
  logic        cpu_req;
  logic        cpu_rw;
  logic [15:0] cpu_addr;
  logic [15:0] cpu_wdata;
  logic        cpu_stall;
  logic [15:0] cpu_rdata;
  logic        cpu_rvalid;

  // DMA / loader port
  logic        dma_req;
  logic        dma_lock;
  logic        dma_rw;
  logic [15:0] dma_addr;
  logic [15:0] dma_wdata;
  logic        dma_gnt;
  logic [15:0] dma_rdata;
  logic        dma_rvalid;

  // Data memory port
  logic        mem_en;
  logic        mem_rw;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_rw, cpu_addr, cpu_wdata,
    output cpu_stall, cpu_rdata, cpu_rvalid,
    input  dma_req, dma_lock, dma_rw, dma_addr, dma_wdata,
    output dma_gnt, dma_rdata, dma_rvalid,
    output mem_en, mem_rw, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output cpu_req, cpu_rw, cpu_addr, cpu_wdata,
    input  cpu_stall, cpu_rdata, cpu_rvalid,
    output dma_req, dma_lock, dma_rw, dma_addr, dma_wdata,
    input  dma_gnt, dma_rdata, dma_rvalid,
    input  mem_en, mem_rw, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/dm_port_arbiter.sv
// dm_port_arbiter: shares one synchronous data memory between the CPU and a
// DMA/loader. At most one access is accepted per cycle; the winner's command
// is registered onto mem_*, and read data returns to its owner two edges
// after acceptance through a pipelined owner tag.
// DMA may take burst ownership (dma_lock), bounded to MAX_LOCK consecutive
// grants, after which the CPU gets exactly one slot before the burst resumes.
// Optional feature macro: DM_ARB_FAIRNESS_EN -- when defined, a starvation
// counter lets a DMA that has waited STARVE_LIMIT cycles win over the CPU;
// when undefined the CPU has strict priority outside a locked burst.
module dm_port_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int MAX_LOCK     = 8
) (
  input  logic             clk,
  input  logic             reset,
  dm_port_arbiter_if.slave bus
);

  localparam int LOCK_W = $clog2(MAX_LOCK + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CPU,
    ST_DMA,
    ST_LOCK
  } state_t;

  state_t            r_state;
  state_t            w_nextState;
  logic [LOCK_W-1:0] r_lockCnt;
  logic [LOCK_W-1:0] w_nextLockCnt;
  logic              r_yield;
  logic              w_nextYield;
  logic              w_cpuGnt;
  logic              w_dmaGnt;
  logic              w_anyGnt;
  logic              w_lockFull;
  logic              w_starved;

  logic              w_selRw;
  logic [15:0]       w_selAddr;
  logic [15:0]       w_selWdata;

  logic              r_memEn;
  logic              r_memRw;
  logic [15:0]       r_memAddr;
  logic [15:0]       r_memWdata;

  logic              r_tag0Valid;
  logic              r_tag0Dma;
  logic              r_tag1Valid;
  logic              r_tag1Dma;

  logic              r_cpuRvalid;
  logic              r_dmaRvalid;
  logic [15:0]       r_cpuRdata;
  logic [15:0]       r_dmaRdata;

  assign w_lockFull = (r_lockCnt == LOCK_W'(MAX_LOCK));

`ifdef DM_ARB_FAIRNESS_EN
  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

  logic [STARVE_W-1:0] r_starveCnt;

  assign w_starved = (r_starveCnt == STARVE_W'(STARVE_LIMIT));

  // Count cycles a pending DMA is passed over; saturate at the limit and
  // restart whenever DMA is served or withdraws its request.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_starveCnt <= '0;
    end else if (!bus.dma_req || w_dmaGnt) begin
      r_starveCnt <= '0;
    end else if (!w_starved) begin
      r_starveCnt <= r_starveCnt + STARVE_W'(1);
    end
  end
`else
  // Strict CPU priority: a waiting DMA never wins by age in this build. The
  // limit stays referenced so both builds share one parameter list.
  localparam bit STARVE_CFG_OK = (STARVE_LIMIT >= 1);

  assign w_starved = 1'b0 && STARVE_CFG_OK;
`endif

  // Pick this cycle's winner and the next owner state / locked-grant count.
  always_comb begin
    w_cpuGnt      = 1'b0;
    w_dmaGnt      = 1'b0;
    w_nextYield   = 1'b0;
    w_nextState   = ST_IDLE;
    w_nextLockCnt = '0;

    if (reset) begin
      if ((r_state == ST_LOCK) && bus.dma_req && !w_lockFull) begin
        w_dmaGnt = 1'b1;
      end else if (r_yield && bus.dma_req && bus.dma_lock) begin
        w_dmaGnt = 1'b1;
      end else if ((r_state == ST_LOCK) && w_lockFull && bus.cpu_req) begin
        w_cpuGnt    = 1'b1;
        w_nextYield = 1'b1;
      end else if (bus.cpu_req && !(bus.dma_req && w_starved)) begin
        w_cpuGnt = 1'b1;
      end else if (bus.dma_req) begin
        w_dmaGnt = 1'b1;
      end
    end

    if (w_dmaGnt) begin
      if (bus.dma_lock) begin
        w_nextState = ST_LOCK;
        if ((r_state == ST_LOCK) && !w_lockFull) begin
          w_nextLockCnt = r_lockCnt + LOCK_W'(1);
        end else begin
          w_nextLockCnt = LOCK_W'(1);
        end
      end else begin
        w_nextState = ST_DMA;
      end
    end else if (w_cpuGnt) begin
      w_nextState = ST_CPU;
    end
  end

  // Owner state, locked-grant count and the one-slot CPU yield flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_lockCnt <= '0;
      r_yield   <= 1'b0;
    end else begin
      r_state   <= w_nextState;
      r_lockCnt <= w_nextLockCnt;
      r_yield   <= w_nextYield;
    end
  end

  assign w_anyGnt   = w_cpuGnt | w_dmaGnt;
  assign w_selRw    = w_dmaGnt ? bus.dma_rw    : bus.cpu_rw;
  assign w_selAddr  = w_dmaGnt ? bus.dma_addr  : bus.cpu_addr;
  assign w_selWdata = w_dmaGnt ? bus.dma_wdata : bus.cpu_wdata;

  // Register the winning command onto the memory port; idle cycles drop the
  // enable and write strobe but keep address/data stable.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_memEn    <= 1'b0;
      r_memRw    <= 1'b0;
      r_memAddr  <= '0;
      r_memWdata <= '0;
    end else begin
      r_memEn <= w_anyGnt;
      r_memRw <= w_anyGnt & w_selRw;
      if (w_anyGnt) begin
        r_memAddr  <= w_selAddr;
        r_memWdata <= w_selWdata;
      end
    end
  end

  // Carry the owner of each accepted read alongside the memory latency so
  // back-to-back reads are steered back in order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tag0Valid <= 1'b0;
      r_tag0Dma   <= 1'b0;
      r_tag1Valid <= 1'b0;
      r_tag1Dma   <= 1'b0;
    end else begin
      r_tag0Valid <= w_anyGnt & ~w_selRw;
      r_tag0Dma   <= w_dmaGnt;
      r_tag1Valid <= r_tag0Valid;
      r_tag1Dma   <= r_tag0Dma;
    end
  end

  // Capture returning memory data for the tagged owner and pulse its rvalid.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cpuRvalid <= 1'b0;
      r_dmaRvalid <= 1'b0;
      r_cpuRdata  <= '0;
      r_dmaRdata  <= '0;
    end else begin
      r_cpuRvalid <= r_tag1Valid & ~r_tag1Dma;
      r_dmaRvalid <= r_tag1Valid &  r_tag1Dma;
      if (r_tag1Valid && !r_tag1Dma) begin
        r_cpuRdata <= bus.mem_rdata;
      end
      if (r_tag1Valid && r_tag1Dma) begin
        r_dmaRdata <= bus.mem_rdata;
      end
    end
  end

  assign bus.cpu_stall  = bus.cpu_req & ~w_cpuGnt;
  assign bus.dma_gnt    = w_dmaGnt;
  assign bus.cpu_rdata  = r_cpuRdata;
  assign bus.cpu_rvalid = r_cpuRvalid;
  assign bus.dma_rdata  = r_dmaRdata;
  assign bus.dma_rvalid = r_dmaRvalid;
  assign bus.mem_en     = r_memEn;
  assign bus.mem_rw     = r_memRw;
  assign bus.mem_addr   = r_memAddr;
  assign bus.mem_wdata  = r_memWdata;

endmodule
